// File: rtl/alu_result_buf.sv
// Result buffer behind the two-cycle ALU: captures results into a FIFO,
// presents them over valid/ready, and issues credits so the ALU never overruns it.
module alu_result_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_i,
    output logic                     credit_o,
    input  logic [WIDTH-1:0]         alu_f,
    input  logic                     alu_valid,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned INF_W = PTR_W + 2;
    localparam int unsigned SUM_W = INF_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [INF_W-1:0] inflight;

    logic             accepted_c;
    logic             pop_c;
    logic             push_c;
    logic             full_c;
    logic             ovf_set_c;
    logic [INF_W-1:0] inflight_nxt_c;
    logic [CNT_W-1:0] count_nxt_c;

    // Flow control and next-state terms, all derived from registered state
    always_comb begin
        accepted_c     = alu_valid && (inflight != '0);
        full_c         = (count == CNT_W'(DEPTH));
        rvalid         = (count != '0);
        rdata          = rvalid ? mem[rptr] : '0;
        pop_c          = rvalid && rready;
        push_c         = accepted_c && (!full_c || pop_c);
        credit_o       = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);
        ovf_set_c      = (issue_i && !credit_o) || (accepted_c && full_c && !pop_c);
        count_nxt_c    = count + CNT_W'(push_c) - CNT_W'(pop_c);
        inflight_nxt_c = inflight + INF_W'(issue_i) - INF_W'(accepted_c);
        // accepted_c needs inflight != 0, so only the upper bound can wrap
        if ((inflight == '1) && issue_i && !accepted_c) begin
            inflight_nxt_c = inflight;
        end
    end

    // Control state; storage below is intentionally left unreset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            inflight <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= count_nxt_c;
            inflight <= inflight_nxt_c;
            if (push_c) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_c) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wptr] <= alu_f;
        end
    end

endmodule
